// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for serial_adder: request side (start, sub, a, b)
// and result side (busy, done, sum, carry_out, overflow).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle two's-complement adder/subtractor, DIGIT bits per cycle, LSB first.
// Optional feature: define SERIAL_ADDER_SAT_EN to saturate sum on signed overflow.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [DIGIT:0]         dsum_s;
  logic                   msb_cin_s;
  logic                   ovf_s;
  logic [WIDTH+DIGIT-1:0] shift_s;
  logic [WIDTH-1:0]       res_next_s;
  logic [WIDTH-1:0]       sum_final_s;

  // Digit slice: add low digit, shift it in at the MSB end, derive final flags.
  always_comb begin
    dsum_s      = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};
    // Carry into the digit's top bit is recovered from that bit's sum = a ^ b ^ cin.
    msb_cin_s   = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ dsum_s[DIGIT-1];
    ovf_s       = msb_cin_s ^ dsum_s[DIGIT];
    shift_s     = {dsum_s[DIGIT-1:0], res_r};
    res_next_s  = shift_s[WIDTH+DIGIT-1:DIGIT];
`ifdef SERIAL_ADDER_SAT_EN
    // Wrapped sign is the inverse of the true sign when overflow occurs.
    sum_final_s = ovf_s ? {~res_next_s[WIDTH-1], {(WIDTH-1){res_next_s[WIDTH-1]}}}
                        : res_next_s;
`else
    sum_final_s = res_next_s;
`endif
  end

  // Control FSM, operand/result shift registers and held outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub;
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_BUSY;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_BUSY: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          res_r   <= res_next_s;
          carry_r <= dsum_s[DIGIT];
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            sum_r   <= sum_final_s;
            cout_r  <= dsum_s[DIGIT];
            ovf_r   <= ovf_s;
          end else begin
            state_r <= ST_BUSY;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = cout_r;
  assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: DIGIT=1 and DIGIT=4 instances, directed steps plus
// random operations checked against an arithmetic reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v = 1'b0;
  logic       sub_v = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] a_v = 8'h00;
  logic [7:0] b_v = 8'h00;
  logic [7:0] last_sum [2];
  int         total = 0;
  int         bad = 0;

`ifdef SERIAL_ADDER_SAT_EN
  localparam logic [7:0] POS_OVF_SUM = 8'h7F;
  localparam logic [7:0] NEG_OVF_SUM = 8'h80;
`else
  localparam logic [7:0] POS_OVF_SUM = 8'h80;
  localparam logic [7:0] NEG_OVF_SUM = 8'h7F;
`endif

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if1 ();
  serial_adder_if #(.WIDTH(8)) if4 ();

  assign if1.start = start_v & ~sel;
  assign if1.sub   = sub_v;
  assign if1.a     = a_v;
  assign if1.b     = b_v;
  assign if4.start = start_v & sel;
  assign if4.sub   = sub_v;
  assign if4.a     = a_v;
  assign if4.b     = b_v;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  wire       o_busy = sel ? if4.busy      : if1.busy;
  wire       o_done = sel ? if4.done      : if1.done;
  wire [7:0] o_sum  = sel ? if4.sum       : if1.sum;
  wire       o_cout = sel ? if4.carry_out : if1.carry_out;
  wire       o_ovf  = sel ? if4.overflow  : if1.overflow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on integers; returns {ovf, cout, sum}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int          sa, sb, sr, ur;
    logic [31:0] ur_bits;
    logic [7:0]  s;
    logic        c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = sub ? sa - sb : sa + sb;
    ur = sub ? int'(a) - int'(b) : int'(a) + int'(b);
    ur_bits = ur;
    s = ur_bits[7:0];
    c = sub ? (a >= b) : (ur > 255);
    v = (sr > 127) || (sr < -128);
`ifdef SERIAL_ADDER_SAT_EN
    if (sr > 127) s = 8'h7F;
    else if (sr < -128) s = 8'h80;
`endif
    return {v, c, s};
  endfunction

  // Called at a negedge: pulse start across one posedge, then check the held state.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic sub);
    a_v = a;
    b_v = b;
    sub_v = sub;
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    chk("launch_busy", o_busy, 1'b1);
    chk("launch_done", o_done, 1'b0);
    chk("launch_hold", o_sum, last_sum[sel]);
  endtask

  task automatic finish_op(input string tag, input int exp_n, input logic [7:0] es,
                           input logic ec, input logic ev);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_sum"}, o_sum, es);
    chk({tag, "_cout"}, o_cout, ec);
    chk({tag, "_ovf"}, o_ovf, ev);
    chk({tag, "_busy"}, o_busy, 1'b0);
    last_sum[sel] = es;
  endtask

  initial begin
    logic [9:0] m;
    logic [7:0] ra, rb;
    logic       rs;
    logic       seen;
    last_sum[0] = 8'h00;
    last_sum[1] = 8'h00;

    // Reset state
    #2;
    chk("rst_busy", if1.busy, 1'b0);
    chk("rst_done", if1.done, 1'b0);
    chk("rst_sum", if1.sum, 8'h00);
    chk("rst_cout", if1.carry_out, 1'b0);
    chk("rst_ovf", if1.overflow, 1'b0);
    chk("rst_sum4", if4.sum, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if1.done === 1'b1 || if4.done === 1'b1) seen = 1'b1;
    end
    chk("idle_no_done", seen, 1'b0);

    // Directed add/sub cases on the DIGIT=1 instance
    sel = 1'b0;
    launch(8'h0F, 8'h01, 1'b0);  finish_op("add_0f_01", 8, 8'h10, 1'b0, 1'b0);
    launch(8'hFF, 8'h01, 1'b0);  finish_op("add_ff_01", 8, 8'h00, 1'b1, 1'b0);
    launch(8'h7F, 8'h01, 1'b0);  finish_op("add_7f_01", 8, POS_OVF_SUM, 1'b0, 1'b1);
    launch(8'h05, 8'h07, 1'b1);  finish_op("sub_05_07", 8, 8'hFE, 1'b0, 1'b0);
    launch(8'h80, 8'h01, 1'b1);  finish_op("sub_80_01", 8, NEG_OVF_SUM, 1'b1, 1'b1);
    launch(8'h5A, 8'h00, 1'b1);  finish_op("sub_5a_00", 8, 8'h5A, 1'b1, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted
    launch(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    a_v = 8'hAA; b_v = 8'h55; sub_v = 1'b1; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    finish_op("ignore", 4, 8'h10, 1'b0, 1'b0);
    launch(8'h22, 8'h11, 1'b0);
    finish_op("b2b", 8, 8'h33, 1'b0, 1'b0);

    // Reset mid-operation
    launch(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", if1.busy, 1'b0);
    chk("mid_rst_done", if1.done, 1'b0);
    chk("mid_rst_sum", if1.sum, 8'h00);
    chk("mid_rst_cout", if1.carry_out, 1'b0);
    chk("mid_rst_ovf", if1.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_sum[0] = 8'h00;
    last_sum[1] = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if1.done === 1'b1) seen = 1'b1;
    end
    chk("mid_rst_no_done", seen, 1'b0);

    // DIGIT=4 instance
    sel = 1'b1;
    launch(8'h0F, 8'h01, 1'b0);  finish_op("d4_add_0f_01", 2, 8'h10, 1'b0, 1'b0);
    launch(8'h80, 8'h01, 1'b1);  finish_op("d4_sub_80_01", 2, NEG_OVF_SUM, 1'b1, 1'b1);

    // Random operations on both instances
    for (int i = 0; i < 48; i++) begin
      sel = i[0];
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      m = model(ra, rb, rs);
      launch(ra, rb, rs);
      finish_op(sel ? "rnd_d4" : "rnd_d1", sel ? 2 : 8, m[7:0], m[8], m[9]);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
